// File: rtl/mpsoc_glip2ahb3_pkg.sv
// ============================================================================
//  Module   : mpsoc_glip2ahb3_pkg
//  Brief    : Shared types and constants for the GLIP-to-AHB3 host master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpsoc_glip2ahb3_pkg;

  typedef enum logic [3:0] {
    ST_HDR   = 4'd0,
    ST_AHI   = 4'd1,
    ST_ALO   = 4'd2,
    ST_WHI   = 4'd3,
    ST_WLO   = 4'd4,
    ST_AADR  = 4'd5,
    ST_ADAT  = 4'd6,
    ST_RHI   = 4'd7,
    ST_RLO   = 4'd8,
    ST_DRAIN = 4'd9,
    ST_STAT  = 4'd10
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Header word layout
  localparam int HDR_WRITE_BIT = 15;
  localparam int HDR_HSIZE_MSB = 14;
  localparam int HDR_HSIZE_LSB = 12;
  localparam int HDR_BEATS_MSB = 7;
  localparam int HDR_BEATS_LSB = 0;

  localparam logic [2:0] HSIZE_MAX = 3'd2;

  localparam logic [15:0] STAT_OK      = 16'h0000;
  localparam logic [15:0] STAT_HRESP   = 16'h8000;
  localparam logic [15:0] STAT_HSIZE   = 16'hC000;
  localparam logic [15:0] STAT_TIMEOUT = 16'hBF00;

endpackage

`default_nettype wire

// File: rtl/mpsoc_glip2ahb3_master.sv
// ============================================================================
//  Module   : mpsoc_glip2ahb3_master
//  Brief    : Turns GLIP command frames into AHB3-Lite single transfers and
//             returns read data plus a status word. Optional hready timeout
//             enabled by defining MPSOC_GLIP2AHB3_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpsoc_glip2ahb3_master
  import mpsoc_glip2ahb3_pkg::*;
#(
  parameter int          PLEN       = 32,
  parameter int          XLEN       = 32,
  parameter int          GLIP_WIDTH = 16,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [GLIP_WIDTH-1:0] glip_in_data,
  input  logic                  glip_in_valid,
  output logic                  glip_in_ready,

  output logic [GLIP_WIDTH-1:0] glip_out_data,
  output logic                  glip_out_valid,
  input  logic                  glip_out_ready,

  output logic                  ahb3_ext_hsel_o,
  output logic [PLEN-1:0]       ahb3_ext_haddr_o,
  output logic [XLEN-1:0]       ahb3_ext_hwdata_o,
  output logic                  ahb3_ext_hwrite_o,
  output logic [2:0]            ahb3_ext_hsize_o,
  output logic [2:0]            ahb3_ext_hburst_o,
  output logic [3:0]            ahb3_ext_hprot_o,
  output logic [1:0]            ahb3_ext_htrans_o,
  output logic                  ahb3_ext_hmastlock_o,
  input  logic [XLEN-1:0]       ahb3_ext_hrdata_i,
  input  logic                  ahb3_ext_hready_i,
  input  logic                  ahb3_ext_hresp_i
);

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [7:0]              last_q, last_d;
  logic [7:0]              beat_q, beat_d;
  logic [GLIP_WIDTH-1:0]   addr_hi_q, addr_hi_d;
  logic [PLEN-1:0]         addr_q, addr_d;
  logic [XLEN-1:0]         wdata_q, wdata_d;
  logic [XLEN-1:0]         rdata_q, rdata_d;
  logic [15:0]             status_q, status_d;
  logic [9:0]              drain_q, drain_d;

  logic                    w_fail;
  logic [15:0]             w_fail_code;
  logic                    w_aphase;
  logic [PLEN-1:0]         w_step;

  assign w_step = PLEN'(1) << hsize_q;

`ifdef MPSOC_GLIP2AHB3_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  logic        w_wait;
  logic        w_tmo;

  assign w_wait = ((state_q == ST_AADR) || (state_q == ST_ADAT)) && !ahb3_ext_hready_i;
  assign w_tmo  = w_wait && (tmo_q == 16'hFFFF);
  assign tmo_d  = w_wait ? tmo_q + 16'd1 : 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= 16'd0;
    else     tmo_q <= tmo_d;
  end

  assign w_aphase = (state_q == ST_AADR) && !w_tmo;
`else
  assign w_aphase = (state_q == ST_AADR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HDR;
      write_q   <= 1'b0;
      hsize_q   <= 3'd0;
      last_q    <= 8'd0;
      beat_q    <= 8'd0;
      addr_hi_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= STAT_OK;
      drain_q   <= 10'd0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      hsize_q   <= hsize_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      addr_hi_q <= addr_hi_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    hsize_d     = hsize_q;
    last_d      = last_q;
    beat_d      = beat_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    drain_d     = drain_q;
    w_fail      = 1'b0;
    w_fail_code = STAT_OK;

    case (state_q)
      ST_HDR: if (glip_in_valid) begin
        write_d  = glip_in_data[HDR_WRITE_BIT];
        hsize_d  = glip_in_data[HDR_HSIZE_MSB:HDR_HSIZE_LSB];
        last_d   = glip_in_data[HDR_BEATS_MSB:HDR_BEATS_LSB];
        beat_d   = 8'd0;
        status_d = STAT_OK;
        state_d  = ST_AHI;
      end
      ST_AHI: if (glip_in_valid) begin
        addr_hi_d = glip_in_data;
        state_d   = ST_ALO;
      end
      ST_ALO: if (glip_in_valid) begin
        addr_d = PLEN'({addr_hi_q, glip_in_data});
        if (hsize_q > HSIZE_MAX) begin
          // Illegal size: swallow every write word, then report
          status_d = STAT_HSIZE;
          drain_d  = 10'({last_q, 1'b0}) + 10'd2;
          state_d  = write_q ? ST_DRAIN : ST_STAT;
        end else begin
          state_d = write_q ? ST_WHI : ST_AADR;
        end
      end
      ST_WHI: if (glip_in_valid) begin
        wdata_d[XLEN-1 -: GLIP_WIDTH] = glip_in_data;
        state_d = ST_WLO;
      end
      ST_WLO: if (glip_in_valid) begin
        wdata_d[GLIP_WIDTH-1:0] = glip_in_data;
        state_d = ST_AADR;
      end
      ST_AADR: if (ahb3_ext_hready_i) state_d = ST_ADAT;
      ST_ADAT: begin
        if (ahb3_ext_hresp_i) begin
          w_fail      = 1'b1;
          w_fail_code = STAT_HRESP | {8'h00, beat_q};
        end else if (ahb3_ext_hready_i) begin
          if (!write_q) begin
            rdata_d = ahb3_ext_hrdata_i;
            state_d = ST_RHI;
          end else if (beat_q == last_q) begin
            state_d = ST_STAT;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_q + w_step;
            state_d = ST_WHI;
          end
        end
      end
      ST_RHI: if (glip_out_ready) state_d = ST_RLO;
      ST_RLO: if (glip_out_ready) begin
        if (beat_q == last_q) begin
          state_d = ST_STAT;
        end else begin
          beat_d  = beat_q + 8'd1;
          addr_d  = addr_q + w_step;
          state_d = ST_AADR;
        end
      end
      ST_DRAIN: if (glip_in_valid) begin
        drain_d = drain_q - 10'd1;
        if (drain_q == 10'd1) state_d = ST_STAT;
      end
      ST_STAT: if (glip_out_ready) state_d = ST_HDR;
      default: state_d = ST_HDR;
    endcase

`ifdef MPSOC_GLIP2AHB3_TIMEOUT_EN
    if (w_tmo) begin
      w_fail      = 1'b1;
      w_fail_code = STAT_TIMEOUT | {8'h00, beat_q};
    end
`endif

    // Abort the remaining beats; the current beat's write words are already consumed
    if (w_fail) begin
      status_d = w_fail_code;
      if (write_q && (beat_q != last_q)) begin
        drain_d = 10'({last_q - beat_q, 1'b0});
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_STAT;
      end
    end
  end

  assign glip_in_ready = (state_q == ST_HDR)  || (state_q == ST_AHI) ||
                         (state_q == ST_ALO)  || (state_q == ST_WHI) ||
                         (state_q == ST_WLO)  || (state_q == ST_DRAIN);

  assign glip_out_valid = (state_q == ST_RHI) || (state_q == ST_RLO) ||
                          (state_q == ST_STAT);

  always_comb begin
    glip_out_data = '0;
    case (state_q)
      ST_RHI:  glip_out_data = rdata_q[XLEN-1 -: GLIP_WIDTH];
      ST_RLO:  glip_out_data = rdata_q[GLIP_WIDTH-1:0];
      ST_STAT: glip_out_data = status_q;
      default: glip_out_data = '0;
    endcase
  end

  assign ahb3_ext_hsel_o      = w_aphase;
  assign ahb3_ext_htrans_o    = w_aphase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb3_ext_hwrite_o    = w_aphase & write_q;
  assign ahb3_ext_hsize_o     = w_aphase ? hsize_q : 3'd0;
  assign ahb3_ext_haddr_o     = addr_q;
  assign ahb3_ext_hwdata_o    = wdata_q;
  assign ahb3_ext_hburst_o    = HBURST_SINGLE;
  assign ahb3_ext_hprot_o     = HPROT_VAL;
  assign ahb3_ext_hmastlock_o = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_mpsoc_glip2ahb3_master.sv
// ============================================================================
//  Module   : tb_mpsoc_glip2ahb3_master
//  Brief    : Directed bench with a frame-level reference model, an AHB slave
//             model and a GLIP host/sink.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mpsoc_glip2ahb3_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] glip_in_data = '0;
  logic        glip_in_valid = 1'b0;
  logic        glip_in_ready;
  logic [15:0] glip_out_data;
  logic        glip_out_valid;
  logic        glip_out_ready = 1'b0;
  logic        hsel, hwrite, hmastlock;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hrdata = '0;
  logic        hready = 1'b1;
  logic        hresp  = 1'b0;

  always #5 clk = ~clk;

  mpsoc_glip2ahb3_master dut (
    .clk                  (clk),
    .rst                  (rst),
    .glip_in_data         (glip_in_data),
    .glip_in_valid        (glip_in_valid),
    .glip_in_ready        (glip_in_ready),
    .glip_out_data        (glip_out_data),
    .glip_out_valid       (glip_out_valid),
    .glip_out_ready       (glip_out_ready),
    .ahb3_ext_hsel_o      (hsel),
    .ahb3_ext_haddr_o     (haddr),
    .ahb3_ext_hwdata_o    (hwdata),
    .ahb3_ext_hwrite_o    (hwrite),
    .ahb3_ext_hsize_o     (hsize),
    .ahb3_ext_hburst_o    (hburst),
    .ahb3_ext_hprot_o     (hprot),
    .ahb3_ext_htrans_o    (htrans),
    .ahb3_ext_hmastlock_o (hmastlock),
    .ahb3_ext_hrdata_i    (hrdata),
    .ahb3_ext_hready_i    (hready),
    .ahb3_ext_hresp_i     (hresp)
  );

  typedef struct {
    logic [31:0] addr;
    logic        w;
    logic [2:0]  sz;
    logic [31:0] data;
  } ahb_t;

  int checks = 0;
  int errors = 0;

  ahb_t        exp_ahb[$];
  logic [15:0] exp_out[$];
  logic [15:0] got_out[$];
  logic [31:0] got_addr[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] wbuf[256];

  int err_beat  = -1;
  int stall_cfg = 0;
  int xfer_idx  = 0;
  int hsel_cnt  = 0;
  int out_cnt   = 0;
  bit out_hold  = 1'b0;

  bit          dphase = 1'b0;
  bit          dp_w, dp_err, err2;
  logic [31:0] dp_addr, dp_wdata;
  int          dp_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Slave, sink and on-the-fly comparison against the model queues
  always @(negedge clk) begin
    if (rst) begin
      dphase = 1'b0;
      hready = 1'b1;
      hresp  = 1'b0;
      glip_out_ready = 1'b0;
    end else begin
      glip_out_ready = !out_hold;
      if (glip_out_valid && glip_out_ready) begin
        got_out.push_back(glip_out_data);
        out_cnt++;
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra actual=%h required=none", glip_out_data);
        end else begin
          chk("out_word", glip_out_data, exp_out.pop_front());
        end
      end
      if (dphase) begin
        if (dp_w && !dp_err) chk("hwdata", hwdata, dp_wdata);
        if (dp_stall > 0) begin
          hready = 1'b0; hresp = 1'b0; dp_stall--;
        end else if (dp_err && !err2) begin
          hready = 1'b0; hresp = 1'b1; err2 = 1'b1;
        end else begin
          hready = 1'b1; hresp = dp_err;
          hrdata = dp_err ? 32'h0 : mem_val(dp_addr);
          dphase = 1'b0;
        end
      end else begin
        hready = 1'b1;
        hresp  = 1'b0;
      end
      if (hready && hsel) begin
        ahb_t e;
        got_addr.push_back(haddr);
        hsel_cnt++;
        if (exp_ahb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ahb_extra actual=%h required=none", haddr);
          e.data = 32'h0;
        end else begin
          e = exp_ahb.pop_front();
          chk("ahb_aphase", {haddr, hwrite, hsize, htrans, hburst, hprot, hmastlock},
              {e.addr, e.w, e.sz, 2'b10, 3'b000, 4'b0011, 1'b0});
        end
        dphase   = 1'b1;
        dp_addr  = haddr;
        dp_w     = hwrite;
        dp_wdata = e.data;
        dp_stall = stall_cfg;
        dp_err   = (xfer_idx == err_beat);
        err2     = 1'b0;
        xfer_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    glip_in_data  = w;
    glip_in_valid = 1'b1;
    while (!glip_in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL in_timeout actual=stalled required=accepted word=%h", w);
    end
    tick();
    glip_in_valid = 1'b0;
  endtask

  // Frame-level model: expected AHB transfers and response words
  task automatic start_frame(input bit w, input logic [2:0] sz, input logic [7:0] nm1,
                             input logic [31:0] a, input int errb, input int stall);
    logic [15:0] st;
    logic [31:0] ad, v;
    got_out.delete();
    got_addr.delete();
    hsel_cnt  = 0;
    xfer_idx  = 0;
    out_cnt   = 0;
    err_beat  = errb;
    stall_cfg = stall;
    if (sz > 3'd2) begin
      exp_out.push_back(16'hC000);
    end else begin
      st = 16'h0000;
      for (int b = 0; b <= int'(nm1); b++) begin
        ad = a + (32'(b) << sz);
        exp_ahb.push_back('{addr: ad, w: w, sz: sz, data: wbuf[b]});
        if (b == errb) begin
          st = 16'h8000 | 16'(b);
          break;
        end
        if (!w) begin
          v = mem_val(ad);
          exp_out.push_back(v[31:16]);
          exp_out.push_back(v[15:0]);
        end
      end
      exp_out.push_back(st);
    end
    send_word({w, sz, 4'h0, nm1});
    send_word(a[31:16]);
    send_word(a[15:0]);
    if (w) begin
      for (int b = 0; b <= int'(nm1); b++) begin
        send_word(wbuf[b][31:16]);
        send_word(wbuf[b][15:0]);
      end
    end
  endtask

  task automatic finish_frame();
    int n = 0;
    while (exp_out.size() > 0 && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=%0d_words_left required=0", exp_out.size());
    end
    tick();
    chk("ahb_left", exp_ahb.size(), 0);
  endtask

  task automatic run_frame(input bit w, input logic [2:0] sz, input logic [7:0] nm1,
                           input logic [31:0] a, input int errb, input int stall);
    start_frame(w, sz, nm1, a, errb, stall);
    finish_frame();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    mem[32'h200] = 32'h1111_1111;
    mem[32'h204] = 32'h2222_2222;
    mem[32'h208] = 32'h3333_3333;
    repeat (3) tick();
    chk("rst_ahb_a", {hsel, htrans, hwrite, hsize, hburst, hprot, hmastlock},
        {1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 4'b0011, 1'b0});
    chk("rst_ahb_b", {haddr, hwdata}, 64'h0);
    chk("rst_glip", {glip_out_valid, glip_out_data}, 17'h0);
    rst = 1'b0;
    tick();

    // Single-beat write (write, hsize 2, one beat)
    wbuf[0] = 32'hDEAD_BEEF;
    run_frame(1'b1, 3'd2, 8'd0, 32'h0000_0100, -1, 0);
    chk("wr1_addr", got_addr[0], 32'h100);
    chk("wr1_stat", {16'(got_out.size()), got_out[0]}, {16'd1, 16'h0000});

    // Three-beat read
    run_frame(1'b0, 3'd2, 8'd2, 32'h0000_0200, -1, 0);
    chk("rd3_cnt", got_out.size(), 7);
    chk("rd3_w0123", {got_out[0], got_out[1], got_out[2], got_out[3]}, 64'h1111_1111_2222_2222);
    chk("rd3_w456", {got_out[4], got_out[5], got_out[6]}, 48'h3333_3333_0000);
    chk("rd3_addr01", {got_addr[0], got_addr[1]}, 64'h0000_0200_0000_0204);
    chk("rd3_addr2", got_addr[2], 32'h208);

    // Write with 5-cycle data-phase stall
    wbuf[0] = 32'hCAFE_F00D;
    run_frame(1'b1, 3'd2, 8'd0, 32'h0000_0140, -1, 5);
    chk("stall_stat", got_out[0], 16'h0000);

    // ERROR on beat 1 of a 3-beat write
    wbuf[0] = 32'h0101_0101; wbuf[1] = 32'h0202_0202; wbuf[2] = 32'h0303_0303;
    run_frame(1'b1, 3'd2, 8'd2, 32'h0000_0180, 1, 0);
    chk("werr_hsel", hsel_cnt, 2);
    chk("werr_stat", got_out[0], 16'h8001);

    // Illegal hsize on a write, then on a read
    run_frame(1'b1, 3'd3, 8'd1, 32'h0000_01C0, -1, 0);
    chk("hsz_w_hsel", hsel_cnt, 0);
    chk("hsz_w_stat", got_out[0], 16'hC000);
    run_frame(1'b0, 3'd5, 8'd0, 32'h0000_01C0, -1, 0);
    chk("hsz_r", {16'(hsel_cnt), got_out[0]}, {16'd0, 16'hC000});

    // Byte reads step by one; word reads wrap at 2^32
    run_frame(1'b0, 3'd0, 8'd2, 32'h0000_0501, -1, 0);
    chk("byte_addr", {got_addr[1], got_addr[2]}, 64'h0000_0502_0000_0503);
    run_frame(1'b0, 3'd2, 8'd1, 32'hFFFF_FFFC, -1, 0);
    chk("wrap_addr", {got_addr[0], got_addr[1]}, 64'hFFFF_FFFC_0000_0000);

    // ERROR on the first beat of a read
    run_frame(1'b0, 3'd2, 8'd1, 32'h0000_0800, 0, 0);
    chk("rerr", {16'(got_out.size()), 16'(hsel_cnt), got_out[0]}, {16'd1, 16'd1, 16'h8000});

    // 256-beat read: counter must not stop early
    run_frame(1'b0, 3'd2, 8'd255, 32'h0000_1000, -1, 0);
    chk("rd256_cnt", {16'(hsel_cnt), 16'(got_out.size())}, {16'd256, 16'd513});
    chk("rd256_last", got_addr[255], 32'h0000_13FC);

    // Back-pressure then reset in the middle of a read
    out_hold = 1'b1;
    start_frame(1'b0, 3'd2, 8'd1, 32'h0000_0300, -1, 0);
    repeat (10) tick();
    chk("hold_ahb", hsel_cnt, 1);
    chk("hold_words", out_cnt, 0);
    out_hold = 1'b0;
    n = 0;
    while (out_cnt < 3 && n < 100) begin
      tick();
      n++;
    end
    out_hold = 1'b1;
    chk("rrst_words", {16'(got_out.size()), got_out[0], got_out[1], got_out[2]},
        {16'd3, 16'hA5A5, 16'h595A, 16'hA5A5});
    tick();
    rst = 1'b1;
    #1;
    chk("rrst_ahb", {hsel, htrans, hwrite, hsize, hburst, hprot, hmastlock, haddr},
        {1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 4'b0011, 1'b0, 32'h0});
    chk("rrst_glip", {glip_out_valid, glip_out_data, hwdata}, 49'h0);
    tick();
    tick();
    rst = 1'b0;
    exp_out.delete();
    exp_ahb.delete();
    out_hold = 1'b0;
    tick();

    // Fresh frame after reset
    wbuf[0] = 32'h1234_5678;
    run_frame(1'b1, 3'd2, 8'd0, 32'h0000_0600, -1, 0);
    chk("post_rst", {got_addr[0], 16'(got_out.size()), got_out[0]}, {32'h600, 16'd1, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
